// File: rtl/load_store_sequencer_if.sv
// load_store_sequencer_if: pipeline-side and memory-side signal bundle of the load/store sequencer
interface load_store_sequencer_if;
  logic        I_LSU_valid;
  logic        I_LSU_we;
  logic [1:0]  I_LSU_size;
  logic        I_LSU_sign;
  logic [31:0] I_LSU_addr;
  logic [31:0] I_LSU_wdata;
  logic        O_LSU_stall;
  logic        O_LSU_done;
  logic [31:0] O_LSU_rdata;
  logic        O_LSU_misalign;
  logic        O_LSU_timeout;
  logic        O_MEM_req;
  logic        O_MEM_we;
  logic [31:0] O_MEM_addr;
  logic [3:0]  O_MEM_be;
  logic [31:0] O_MEM_wdata;
  logic        I_MEM_ack;
  logic [31:0] I_MEM_rdata;
  modport slave (
    input  I_LSU_valid, I_LSU_we, I_LSU_size, I_LSU_sign, I_LSU_addr, I_LSU_wdata, I_MEM_ack, I_MEM_rdata,
    output O_LSU_stall, O_LSU_done, O_LSU_rdata, O_LSU_misalign, O_LSU_timeout,
    output O_MEM_req, O_MEM_we, O_MEM_addr, O_MEM_be, O_MEM_wdata
  );
  modport master (
    output I_LSU_valid, I_LSU_we, I_LSU_size, I_LSU_sign, I_LSU_addr, I_LSU_wdata, I_MEM_ack, I_MEM_rdata,
    input  O_LSU_stall, O_LSU_done, O_LSU_rdata, O_LSU_misalign, O_LSU_timeout,
    input  O_MEM_req, O_MEM_we, O_MEM_addr, O_MEM_be, O_MEM_wdata
  );
endinterface

// File: rtl/load_store_sequencer.sv
// load_store_sequencer: sequences MEM-stage loads/stores over a variable-latency req/ack memory port
module load_store_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 7
) (
  input logic I_LSU_clk,
  input logic I_LSU_rst,
  load_store_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic sign_q, sign_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0] mem_be_q, mem_be_d;
  logic done_q, done_d, misalign_q, misalign_d, timeout_q, timeout_d;
  logic [31:0] rdata_q, rdata_d;
  logic illegal, stall;
  logic [3:0] be_new;
  logic [31:0] wdata_new, shifted, load_ext;
  // request decode (legality, byte enables, lane replication) and load-lane extraction
  always_comb begin
    illegal = (bus.I_LSU_size == 2'b11) || (bus.I_LSU_size == 2'b01 && bus.I_LSU_addr[0]) ||
              (bus.I_LSU_size == 2'b00 && bus.I_LSU_addr[1:0] != 2'b00);
    be_new = bus.I_LSU_size == 2'b00 ? 4'b1111 :
             bus.I_LSU_size == 2'b01 ? (bus.I_LSU_addr[1] ? 4'b1100 : 4'b0011) :
             4'b0001 << bus.I_LSU_addr[1:0];
    wdata_new = !bus.I_LSU_we ? 32'd0 :
                bus.I_LSU_size == 2'b00 ? bus.I_LSU_wdata :
                bus.I_LSU_size == 2'b01 ? {2{bus.I_LSU_wdata[15:0]}} : {4{bus.I_LSU_wdata[7:0]}};
    shifted = bus.I_MEM_rdata >> {off_q, 3'b000};
    load_ext = size_q == 2'b00 ? shifted :
               size_q == 2'b01 ? {{16{sign_q & shifted[15]}}, shifted[15:0]} :
               {{24{sign_q & shifted[7]}}, shifted[7:0]};
  end
  // next state; memory outputs are loaded on accept, held through ACCESS and cleared on leaving it
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    size_d = size_q;
    off_d = off_q;
    sign_d = sign_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_be_d = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    done_d = 1'b0;
    misalign_d = 1'b0;
    timeout_d = 1'b0;
    rdata_d = 32'd0;
    stall = 1'b0;
    case (state_q)
      IDLE: begin
        stall = bus.I_LSU_valid;
        if (bus.I_LSU_valid && illegal) begin
          state_d = RESP;
          done_d = 1'b1;
          misalign_d = 1'b1;
        end else if (bus.I_LSU_valid) begin
          state_d = ACCESS;
          size_d = bus.I_LSU_size;
          off_d = bus.I_LSU_addr[1:0];
          sign_d = bus.I_LSU_sign;
          mem_req_d = 1'b1;
          mem_we_d = bus.I_LSU_we;
          mem_addr_d = {bus.I_LSU_addr[31:2], 2'b00};
          mem_be_d = be_new;
          mem_wdata_d = wdata_new;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (bus.I_MEM_ack || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          done_d = 1'b1;
          timeout_d = !bus.I_MEM_ack;
          rdata_d = (bus.I_MEM_ack && !mem_we_q) ? load_ext : 32'd0;
          mem_req_d = 1'b0;
          mem_we_d = 1'b0;
          mem_addr_d = 32'd0;
          mem_be_d = 4'd0;
          mem_wdata_d = 32'd0;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs with synchronous reset
  always_ff @(posedge I_LSU_clk) begin
    if (I_LSU_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      size_q <= 2'd0;
      off_q <= 2'd0;
      sign_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_be_q <= 4'd0;
      mem_wdata_q <= 32'd0;
      done_q <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      size_q <= size_d;
      off_q <= off_d;
      sign_q <= sign_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      done_q <= done_d;
      misalign_q <= misalign_d;
      timeout_q <= timeout_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.O_LSU_stall = stall;
  assign bus.O_LSU_done = done_q;
  assign bus.O_LSU_rdata = rdata_q;
  assign bus.O_LSU_misalign = misalign_q;
  assign bus.O_LSU_timeout = timeout_q;
  assign bus.O_MEM_req = mem_req_q;
  assign bus.O_MEM_we = mem_we_q;
  assign bus.O_MEM_addr = mem_addr_q;
  assign bus.O_MEM_be = mem_be_q;
  assign bus.O_MEM_wdata = mem_wdata_q;
endmodule

// File: tb/tb_load_store_sequencer.sv
// tb_load_store_sequencer: directed checks of the load/store sequencer with TIMEOUT=16
module tb_load_store_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  load_store_sequencer_if bus();
  load_store_sequencer #(.TIMEOUT(16), .CNT_W(5)) dut (.I_LSU_clk(clk), .I_LSU_rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int reqs, lat;
  logic [31:0] rdata, maddr, mwdata;
  logic [3:0] mbe;
  logic mis, tmo, stall_first, stall_done, mwe, got_done;

  task automatic do_access(input logic we, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rd);
    bus.I_LSU_valid = 1'b1;
    bus.I_LSU_we = we;
    bus.I_LSU_size = size;
    bus.I_LSU_sign = sign;
    bus.I_LSU_addr = addr;
    bus.I_LSU_wdata = wdata;
    reqs = 0; lat = 0; got_done = 1'b0; rdata = 32'hx; mis = 1'bx; tmo = 1'bx; stall_done = 1'bx;
    maddr = 32'hx; mwdata = 32'hx; mbe = 4'hx; mwe = 1'bx;
    #1 stall_first = bus.O_LSU_stall;
    for (int c = 1; c <= 40 && !got_done; c++) begin
      @(negedge clk);
      bus.I_MEM_ack = 1'b0;
      bus.I_MEM_rdata = 32'd0;
      if (bus.O_LSU_done) begin
        got_done = 1'b1;
        lat = c;
        rdata = bus.O_LSU_rdata;
        mis = bus.O_LSU_misalign;
        tmo = bus.O_LSU_timeout;
        #1 stall_done = bus.O_LSU_stall;
      end else if (bus.O_MEM_req) begin
        reqs++;
        if (reqs == 1) begin
          maddr = bus.O_MEM_addr; mwdata = bus.O_MEM_wdata; mbe = bus.O_MEM_be; mwe = bus.O_MEM_we;
        end
        if (reqs == ack_at) begin
          bus.I_MEM_ack = 1'b1;
          bus.I_MEM_rdata = rd;
        end
      end
    end
    bus.I_LSU_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if ({bus.O_MEM_req, bus.O_MEM_we, bus.O_MEM_addr, bus.O_MEM_be, bus.O_MEM_wdata} !== 70'd0) begin
      bad++; $display("FAIL reset_mem got req=%b we=%b addr=%h be=%b wdata=%h exp all 0", bus.O_MEM_req, bus.O_MEM_we, bus.O_MEM_addr, bus.O_MEM_be, bus.O_MEM_wdata); end
    total++; if ({bus.O_LSU_done, bus.O_LSU_rdata, bus.O_LSU_misalign, bus.O_LSU_timeout} !== 35'd0) begin
      bad++; $display("FAIL reset_lsu got done=%b rdata=%h mis=%b tmo=%b exp all 0", bus.O_LSU_done, bus.O_LSU_rdata, bus.O_LSU_misalign, bus.O_LSU_timeout); end
    total++; if (bus.O_LSU_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.O_LSU_stall); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lb_signed;
    do_access(1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'h0, 2, 32'h80FF_1234);
    total++; if (got_done !== 1'b1) begin bad++; $display("FAIL lb_done got=%b exp=1", got_done); end
    total++; if (maddr !== 32'h0000_1000) begin bad++; $display("FAIL lb_addr got=%h exp=00001000", maddr); end
    total++; if (mbe !== 4'b1000) begin bad++; $display("FAIL lb_be got=%b exp=1000", mbe); end
    total++; if (mwe !== 1'b0 || mwdata !== 32'd0) begin bad++; $display("FAIL lb_we_wdata got we=%b wdata=%h exp 0/0", mwe, mwdata); end
    total++; if (reqs !== 2) begin bad++; $display("FAIL lb_req_cycles got=%0d exp=2", reqs); end
    total++; if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", rdata); end
    total++; if (stall_first !== 1'b1 || stall_done !== 1'b0) begin bad++; $display("FAIL lb_stall got first=%b done=%b exp 1/0", stall_first, stall_done); end
    total++; if (mis !== 1'b0 || tmo !== 1'b0) begin bad++; $display("FAIL lb_flags got mis=%b tmo=%b exp 0/0", mis, tmo); end
  endtask

  task automatic test_sh;
    do_access(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 1, 32'hFFFF_FFFF);
    total++; if (mwe !== 1'b1) begin bad++; $display("FAIL sh_we got=%b exp=1", mwe); end
    total++; if (mbe !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b exp=1100", mbe); end
    total++; if (mwdata !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_wdata got=%h exp=beefbeef", mwdata); end
    total++; if (maddr !== 32'h0000_2000) begin bad++; $display("FAIL sh_addr got=%h exp=00002000", maddr); end
    total++; if (lat !== 2) begin bad++; $display("FAIL sh_latency got=%0d exp=2", lat); end
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL sh_rdata got=%h exp=00000000", rdata); end
  endtask

  task automatic test_sb;
    do_access(1'b1, 2'b10, 1'b0, 32'h0000_2001, 32'h1234_56A5, 1, 32'h0);
    total++; if (mbe !== 4'b0010 || mwdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_lanes got be=%b wdata=%h exp 0010/a5a5a5a5", mbe, mwdata); end
  endtask

  task automatic test_misalign;
    do_access(1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'h0, 1, 32'h1111_1111);
    total++; if (mis !== 1'b1 || tmo !== 1'b0) begin bad++; $display("FAIL lw_mis_flags got mis=%b tmo=%b exp 1/0", mis, tmo); end
    total++; if (lat !== 1) begin bad++; $display("FAIL lw_mis_latency got=%0d exp=1", lat); end
    total++; if (reqs !== 0) begin bad++; $display("FAIL lw_mis_req got=%0d exp=0", reqs); end
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL lw_mis_rdata got=%h exp=0", rdata); end
    total++; if (stall_first !== 1'b1 || stall_done !== 1'b0) begin bad++; $display("FAIL lw_mis_stall got first=%b done=%b exp 1/0", stall_first, stall_done); end
    do_access(1'b1, 2'b11, 1'b0, 32'h0000_3000, 32'h5, 1, 32'h0);
    total++; if (mis !== 1'b1 || lat !== 1 || reqs !== 0 || rdata !== 32'd0) begin
      bad++; $display("FAIL size11 got mis=%b lat=%0d reqs=%0d rdata=%h exp 1/1/0/0", mis, lat, reqs, rdata); end
    do_access(1'b0, 2'b01, 1'b0, 32'h0000_3003, 32'h0, 1, 32'h0);
    total++; if (mis !== 1'b1 || reqs !== 0) begin bad++; $display("FAIL half_odd got mis=%b reqs=%0d exp 1/0", mis, reqs); end
  endtask

  task automatic test_timeout;
    do_access(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'h0, 0, 32'h0);
    total++; if (reqs !== 16) begin bad++; $display("FAIL to_req_cycles got=%0d exp=16", reqs); end
    total++; if (tmo !== 1'b1 || mis !== 1'b0) begin bad++; $display("FAIL to_flags got tmo=%b mis=%b exp 1/0", tmo, mis); end
    total++; if (lat !== 17 || rdata !== 32'd0) begin bad++; $display("FAIL to_done got lat=%0d rdata=%h exp 17/0", lat, rdata); end
    do_access(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'h0, 16, 32'h1234_5678);
    total++; if (reqs !== 16 || tmo !== 1'b0) begin bad++; $display("FAIL to_ack_last got reqs=%0d tmo=%b exp 16/0", reqs, tmo); end
    total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL to_ack_rdata got=%h exp=12345678", rdata); end
  endtask

  task automatic test_reset_mid;
    int r = 0;
    int seen = 0;
    bus.I_LSU_valid = 1'b1; bus.I_LSU_we = 1'b0; bus.I_LSU_size = 2'b00; bus.I_LSU_sign = 1'b0;
    bus.I_LSU_addr = 32'h0000_4000; bus.I_LSU_wdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.O_MEM_req === 1'b1) r++;
    end
    total++; if (r !== 3) begin bad++; $display("FAIL rmid_req_before got=%0d exp=3", r); end
    rst = 1'b1; bus.I_LSU_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.O_MEM_req !== 1'b0 || bus.O_LSU_done !== 1'b0) begin
      bad++; $display("FAIL rmid_after got req=%b done=%b exp 0/0", bus.O_MEM_req, bus.O_LSU_done); end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.O_LSU_done !== 1'b0 || bus.O_MEM_req !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid_quiet got=%0d active cycles exp=0", seen); end
  endtask

  task automatic test_half_loads;
    do_access(1'b0, 2'b01, 1'b0, 32'h0000_5002, 32'h0, 1, 32'h9ABC_1234);
    total++; if (mbe !== 4'b1100) begin bad++; $display("FAIL lhu_be got=%b exp=1100", mbe); end
    total++; if (rdata !== 32'h0000_9ABC) begin bad++; $display("FAIL lhu_rdata got=%h exp=00009abc", rdata); end
    do_access(1'b0, 2'b01, 1'b1, 32'h0000_5002, 32'h0, 1, 32'h9ABC_1234);
    total++; if (rdata !== 32'hFFFF_9ABC) begin bad++; $display("FAIL lh_rdata got=%h exp=ffff9abc", rdata); end
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_5001, 32'h0, 3, 32'h0000_8000);
    total++; if (rdata !== 32'h0000_0080 || mbe !== 4'b0010) begin bad++; $display("FAIL lbu got rdata=%h be=%b exp 00000080/0010", rdata, mbe); end
  endtask

  initial begin
    bus.I_LSU_valid = 1'b0; bus.I_LSU_we = 1'b0; bus.I_LSU_size = 2'b00; bus.I_LSU_sign = 1'b0;
    bus.I_LSU_addr = 32'h0; bus.I_LSU_wdata = 32'h0; bus.I_MEM_ack = 1'b0; bus.I_MEM_rdata = 32'h0;
    test_reset;
    test_lb_signed;
    test_sh;
    test_sb;
    test_misalign;
    test_timeout;
    test_reset_mid;
    test_half_loads;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
- Sequences every data-memory access issued by the MEM stage of the MIPS core over a variable-latency req/ack memory port.
- For stores, generates the word-aligned address, byte enables and lane-replicated write data.
- For loads, extracts the addressed byte or halfword from the returned word and sign- or zero-extends it.
- Stalls the pipeline until the access finishes and flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT, 64: maximum number of ACCESS cycles without I_MEM_ack before the access is aborted. Must be at least 2.
- CNT_W, 7: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- I_LSU_clk  in  1  clock; all state updates on the rising edge.
- I_LSU_rst  in  1  synchronous reset, active-high.
- I_LSU_valid  in  1  pipeline presents an access; held stable while O_LSU_stall=1.
- I_LSU_we  in  1  1=store, 0=load.
- I_LSU_size  in  2  00=word, 01=half, 10=byte, 11=illegal.
- I_LSU_sign  in  1  loads: 1=sign-extend, 0=zero-extend; ignored for word and stores.
- I_LSU_addr  in  32  byte address.
- I_LSU_wdata  in  32  store data, right-justified.
- O_LSU_stall  out  1  pipeline must hold.
- O_LSU_done  out  1  one-cycle pulse, access complete.
- O_LSU_rdata  out  32  extended load result; valid while O_LSU_done=1, otherwise 0.
- O_LSU_misalign  out  1  one-cycle pulse with done; access rejected.
- O_LSU_timeout  out  1  one-cycle pulse with done; memory never acked.
- O_MEM_req  out  1  memory request, held until ack.
- O_MEM_we  out  1  write strobe.
- O_MEM_addr  out  32  {addr[31:2],2'b00}.
- O_MEM_be  out  4  byte enables; be[k] covers bits [8k+7:8k].
- O_MEM_wdata  out  32  lane-replicated store data.
- I_MEM_ack  in  1  memory accepted the write or returned read data this cycle.
- I_MEM_rdata  in  32  read data; valid when I_MEM_ack=1.

Behaviour:
- Reset:
  - Synchronous reset forces state IDLE and clears the counter and captured operands.
  - All registered outputs go to 0: O_MEM_req, O_MEM_we, O_MEM_addr, O_MEM_be, O_MEM_wdata, O_LSU_done, O_LSU_rdata, O_LSU_misalign, O_LSU_timeout.
  - Reset in ACCESS drops O_MEM_req at that edge and abandons the access; no done pulse is produced.
- Byte order: little-endian. Byte at addr[1:0]=k occupies bits [8k+7:8k].
- States: IDLE, ACCESS, RESP.
- IDLE:
  - O_LSU_stall = I_LSU_valid, combinational.
  - If valid and legal, capture operands, drive the memory outputs from registers next cycle, and go to ACCESS.
  - If valid and illegal, go to RESP with misalign set and no memory request.
  - Illegal means: size=11; size=01 with addr[0]=1; size=00 with addr[1:0]!=0.
- ACCESS:
  - O_MEM_req=1, O_LSU_stall=1, counter increments each cycle.
  - I_MEM_ack=1 goes to RESP. For loads, the extracted and extended result is registered from I_MEM_rdata.
  - Ack absent on the TIMEOUT-th ACCESS cycle goes to RESP with timeout set and rdata=0.
  - Ack on that same cycle wins over timeout.
- RESP:
  - O_MEM_req=0, O_LSU_stall=0, O_LSU_done=1 for exactly one cycle; misalign and timeout pulse here if set.
  - Return to IDLE. I_LSU_valid is ignored in RESP because it still belongs to the finished access.
- Minimum latency is 3 cycles (accept, ACCESS with immediate ack, RESP). Back-to-back accesses therefore have one bubble.
- Byte enables:
  - Word: 1111.
  - Half: 0011 if addr[1]=0, 1100 if addr[1]=1.
  - Byte: one-hot 1<<addr[1:0].
  - Applied to both loads and stores.
- Write data:
  - Word: as is.
  - Half: {2{wdata[15:0]}}.
  - Byte: {4{wdata[7:0]}}.
  - Loads drive 0.
- Load extraction: shift rdata right by 8*addr[1:0], then apply the size and sign rules:
  - Word: unmodified.
  - Half: 16-bit sign- or zero-extension.
  - Byte: 24-bit sign- or zero-extension.
- Store result: O_LSU_rdata=0.
- Memory outputs stay stable throughout ACCESS.

Test Plan:
- Reset: assert I_LSU_rst 2 cycles -> every output 0, O_LSU_stall=0 with valid=0.
- LB signed, addr 0x00001003, ack 2 cycles after req with rdata 0x80FF1234 -> O_MEM_addr 0x00001000, be 1000, req high 2 cycles, done pulse with rdata 0xFFFFFF80, stall low in the done cycle.
- SH, addr 0x00002002, wdata 0x0000BEEF, immediate ack -> O_MEM_we=1, be 1100, O_MEM_wdata 0xBEEFBEEF, done exactly 2 cycles after accept, rdata 0.
- LW, addr 0x00003001 -> misalign and done pulse next cycle, O_MEM_req never asserted, rdata 0, stall high 1 cycle; also size=11 -> same response.
- Timeout with TIMEOUT=16: LW 0x00004000, ack held 0 -> req high exactly 16 cycles, then timeout and done pulse, rdata 0. Repeat with ack on the 16th cycle -> normal done, no timeout.
- Reset in the 3rd ACCESS cycle -> req low after that edge, no done. Then LHU 0x00005002 with rdata 0x9ABC1234 -> be 1100, rdata 0x00009ABC; LH same -> 0xFFFF9ABC.
